pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised pipeline-stage register carrying a PC/instruction pair between two adjacent CPU stages, for example IF→ID. It is the generalised successor to the fixed IF/ID latch: it adds a valid/ready handshake, a flush input and an optional skid entry, so that a downstream stall never creates a combinational ready path back to the upstream stage. One instance sits on each stage boundary of the toy_cpu pipeline.

## Interface
- ADDR_W, default 32: PC width in bits.
- DATA_W, default 32: instruction/payload width in bits.
- SKID, default 1: selects the storage mode.
  - 1: two-entry skid mode; up_ready is registered.
  - 0: single register; up_ready is combinational.
- clk, input, 1: the only clock; all state updates on the rising edge.
- rst, input, 1: reset; asynchronous, active-low (rst=0 resets).
- up_valid, input, 1: upstream offers a beat.
- up_ready, output, 1: the stage accepts a beat this cycle.
- up_pc, input, ADDR_W: upstream PC.
- up_inst, input, DATA_W: upstream instruction.
- flush, input, 1: discard all held beats and any beat offered this cycle.
- dn_valid, output, 1: dn_pc/dn_inst hold a valid beat.
- dn_ready, input, 1: downstream consumes the beat.
- dn_pc, output, ADDR_W: PC presented downstream.
- dn_inst, output, DATA_W: instruction presented downstream.

## Operation
- Fire definitions:
  - up_fire = up_valid & up_ready & !flush.
  - dn_fire = dn_valid & dn_ready.
- Storage: main entry {pc, inst} plus, when SKID=1, a skid entry. Both are cleared to zero on reset and on flush.
- Output mapping:
  - dn_pc/dn_inst always come from the main entry.
  - When dn_valid=0 they read all-zero (NOP bubble, ZERO_WORD).
- States (SKID=1): EMPTY, ONE, TWO.
  - EMPTY: up_fire → ONE, beat loaded into main.
  - ONE, up_fire & dn_fire → ONE, main replaced by the new beat.
  - ONE, up_fire & !dn_fire → TWO, new beat written to skid.
  - ONE, !up_fire & dn_fire → EMPTY.
  - ONE, neither fire → ONE, hold.
  - TWO: up_ready=0. dn_fire → ONE, skid copied to main and skid cleared. Otherwise hold.
- Outputs per state (SKID=1):
  - dn_valid = (state != EMPTY).
  - up_ready = (state != TWO). It is a registered decode of state, with no dependence on dn_ready.
- SKID=0:
  - State is the single bit dn_valid.
  - up_ready = !dn_valid | dn_ready.
  - The main entry loads on up_fire and clears to invalid on dn_fire without up_fire.
- Flush:
  - Highest priority; next state is EMPTY regardless of fires.
  - A beat offered in the flush cycle is dropped.
  - A dn_fire in the flush cycle still counts as consumed downstream.
- Stability: while dn_valid=1 and dn_ready=0, dn_pc/dn_inst do not change.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush.

## Timing
- Latency: a beat accepted at edge N appears on dn_* after edge N; dn_fire is possible in cycle N+1.
- Throughput: 1 beat/cycle sustained while dn_ready=1, in both modes.
- SKID=1 stall response: after dn_ready drops, up_ready falls one cycle later, once the skid entry is filled. That in-flight beat lands in skid and is not lost.
- Reset: asynchronous assert gives immediately state=EMPTY, dn_valid=0, dn_pc=0, dn_inst=0, and up_ready=1 in both modes. SKID=0 up_ready is combinational (!dn_valid | dn_ready), so it is forced high by dn_valid=0. Deassert takes effect at the next rising clk.
- Reset mid-operation: held beats are discarded and no output glitches to a stale payload.
- flush: sampled at the edge; dn_valid=0 from the following cycle.

## Structure
- The existing shared define header holds:
  - ZERO_WORD.
  - Default widths (INST_ADDR_BUS/INST_BUS map to ADDR_W=32/DATA_W=32).
  - State encodings PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2.
- Sub-module pipe_entry: one {valid, pc, inst} register with load/clear and async active-low reset. It is instantiated once per storage entry (main, skid). The SKID generate branch omits the skid instance.

## Test plan
- Reset: rst=0 mid-stream with TWO occupied → dn_valid=0, dn_pc=0, dn_inst=0 and up_ready=1 immediately, without waiting for a clk edge.
- Streaming, SKID=1, dn_ready=1: PCs 0x00,0x04,0x08,0x0C offered back-to-back → same order out, one cycle later, one per cycle.
- Stall: dn_ready=0 while streaming 0x10,0x14 → state TWO, up_ready=0 the next cycle, dn_pc holds 0x10. dn_ready=1 → 0x10 then 0x14 with no loss.
- Flush in TWO with up_valid=1 (pc 0x20) → next cycle dn_valid=0 and 0x20 is never emitted. The following beat 0x24 passes normally.
- SKID=0, dn_ready=0 with dn_valid=1 → up_ready=0 in the same cycle. dn_ready=1 with up_valid=1 → main replaced, throughput 1/cycle.
- Random valid/ready/flush, 10k cycles, both SKID values → scoreboard order and flush-drop checks pass; payload is stable under stall.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared widths, bubble word and skid state encodings for pipe_stage
package pipe_stage_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_t;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one {valid, pc, inst} storage entry with load/clear
module pipe_entry
    import pipe_stage_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int DATA_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [DATA_W-1:0] d_inst,
    output logic              q_valid,
    output logic [ADDR_W-1:0] q_pc,
    output logic [DATA_W-1:0] q_inst
);

    // Clear wins over load so a flush always leaves an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_pc    <= '0;
            q_inst  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_pc    <= '0;
            q_inst  <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q_pc    <= d_pc;
            q_inst  <= d_inst;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline register for a PC/instruction pair with flush and optional skid entry
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int DATA_W = INST_BUS,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic [DATA_W-1:0] up_inst,
    input  logic              flush,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [ADDR_W-1:0] dn_pc,
    output logic [DATA_W-1:0] dn_inst
);

    logic              up_fire;
    logic              dn_fire;
    logic              main_load;
    logic              main_clear;
    logic              main_valid_d;
    logic              main_valid;
    logic [ADDR_W-1:0] main_pc_d;
    logic [DATA_W-1:0] main_inst_d;

    assign up_fire  = up_valid & up_ready & ~flush;
    assign dn_fire  = dn_valid & dn_ready;
    // Main entry is valid exactly when the stage is not EMPTY.
    assign dn_valid = main_valid;

    pipe_entry #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .d_valid (main_valid_d),
        .d_pc    (main_pc_d),
        .d_inst  (main_inst_d),
        .q_valid (main_valid),
        .q_pc    (dn_pc),
        .q_inst  (dn_inst)
    );

    generate
        if (SKID != 0) begin : g_skid
            ps_state_t         state;
            ps_state_t         state_nxt;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [ADDR_W-1:0] skid_pc;
            logic [DATA_W-1:0] skid_inst;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) state <= PS_EMPTY;
                else      state <= state_nxt;
            end

            assign up_ready = (state != PS_TWO);

            always_comb begin
                state_nxt    = state;
                main_load    = 1'b0;
                main_clear   = 1'b0;
                main_valid_d = 1'b1;
                main_pc_d    = up_pc;
                main_inst_d  = up_inst;
                skid_load    = 1'b0;
                skid_clear   = 1'b0;
                if (flush) begin
                    state_nxt  = PS_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    unique case (state)
                        PS_EMPTY: begin
                            if (up_fire) begin
                                main_load = 1'b1;
                                state_nxt = PS_ONE;
                            end
                        end
                        PS_ONE: begin
                            if (up_fire && dn_fire) begin
                                main_load = 1'b1;
                            end else if (up_fire) begin
                                skid_load = 1'b1;
                                state_nxt = PS_TWO;
                            end else if (dn_fire) begin
                                main_clear = 1'b1;
                                state_nxt  = PS_EMPTY;
                            end
                        end
                        PS_TWO: begin
                            // The skid beat is older than anything upstream, so it moves up first.
                            if (dn_fire) begin
                                main_load    = 1'b1;
                                main_valid_d = skid_valid;
                                main_pc_d    = skid_pc;
                                main_inst_d  = skid_inst;
                                skid_clear   = 1'b1;
                                state_nxt    = PS_ONE;
                            end
                        end
                        default: begin
                            main_clear = 1'b1;
                            skid_clear = 1'b1;
                            state_nxt  = PS_EMPTY;
                        end
                    endcase
                end
            end

            pipe_entry #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .d_valid (1'b1),
                .d_pc    (up_pc),
                .d_inst  (up_inst),
                .q_valid (skid_valid),
                .q_pc    (skid_pc),
                .q_inst  (skid_inst)
            );
        end else begin : g_reg
            assign up_ready = ~main_valid | dn_ready;

            always_comb begin
                main_valid_d = 1'b1;
                main_pc_d    = up_pc;
                main_inst_d  = up_inst;
                main_load    = up_fire;
                main_clear   = flush | (dn_fire & ~up_fire);
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed and randomized checks of pipe_stage in skid and single-register modes
module tb_pipe_stage;

    logic        clk;
    logic        rst;
    logic        a_up_valid, a_up_ready, a_flush, a_dn_valid, a_dn_ready;
    logic [31:0] a_up_pc, a_up_inst, a_dn_pc, a_dn_inst;
    logic        b_up_valid, b_up_ready, b_flush, b_dn_valid, b_dn_ready;
    logic [31:0] b_up_pc, b_up_inst, b_dn_pc, b_dn_inst;

    int tests;
    int fails;

    logic [31:0] qa_pc[$], qa_inst[$], qb_pc[$], qb_inst[$];

    pipe_stage #(.ADDR_W(32), .DATA_W(32), .SKID(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .up_valid(a_up_valid), .up_ready(a_up_ready), .up_pc(a_up_pc), .up_inst(a_up_inst),
        .flush(a_flush),
        .dn_valid(a_dn_valid), .dn_ready(a_dn_ready), .dn_pc(a_dn_pc), .dn_inst(a_dn_inst)
    );

    pipe_stage #(.ADDR_W(32), .DATA_W(32), .SKID(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .up_valid(b_up_valid), .up_ready(b_up_ready), .up_pc(b_up_pc), .up_inst(b_up_inst),
        .flush(b_flush),
        .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_pc(b_dn_pc), .dn_inst(b_dn_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (a_dn_valid !== 1'b0) begin fails++; $display("FAIL reset_a_dn_valid got %0b want 0", a_dn_valid); end
        tests++; if (a_dn_pc !== 32'h0) begin fails++; $display("FAIL reset_a_dn_pc got %h want 0", a_dn_pc); end
        tests++; if (a_dn_inst !== 32'h0) begin fails++; $display("FAIL reset_a_dn_inst got %h want 0", a_dn_inst); end
        tests++; if (a_up_ready !== 1'b1) begin fails++; $display("FAIL reset_a_up_ready got %0b want 1", a_up_ready); end
        tests++; if (b_dn_valid !== 1'b0) begin fails++; $display("FAIL reset_b_dn_valid got %0b want 0", b_dn_valid); end
        tests++; if (b_up_ready !== 1'b1) begin fails++; $display("FAIL reset_b_up_ready got %0b want 1", b_up_ready); end
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_stream();
        a_dn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_up_valid = 1'b1;
            a_up_pc    = 32'(i * 4);
            a_up_inst  = inst_of(32'(i * 4));
            tests++; if (a_up_ready !== 1'b1) begin fails++; $display("FAIL stream_up_ready beat %0d got %0b want 1", i, a_up_ready); end
            step();
            tests++; if (a_dn_valid !== 1'b1 || a_dn_pc !== 32'(i * 4) || a_dn_inst !== inst_of(32'(i * 4))) begin
                fails++; $display("FAIL stream_out beat %0d got v=%0b pc=%h inst=%h want v=1 pc=%h", i, a_dn_valid, a_dn_pc, a_dn_inst, 32'(i * 4));
            end
        end
        a_up_valid = 1'b0;
        step();
        tests++; if (a_dn_valid !== 1'b0 || a_dn_pc !== 32'h0) begin fails++; $display("FAIL stream_drain got v=%0b pc=%h want v=0 pc=0", a_dn_valid, a_dn_pc); end
    endtask

    task automatic test_stall();
        a_dn_ready = 1'b0;
        a_up_valid = 1'b1; a_up_pc = 32'h10; a_up_inst = inst_of(32'h10);
        step();
        tests++; if (a_dn_pc !== 32'h10 || a_up_ready !== 1'b1) begin fails++; $display("FAIL stall_one got pc=%h rdy=%0b want pc=10 rdy=1", a_dn_pc, a_up_ready); end
        a_up_pc = 32'h14; a_up_inst = inst_of(32'h14);
        step();
        tests++; if (a_up_ready !== 1'b0) begin fails++; $display("FAIL stall_two_ready got %0b want 0", a_up_ready); end
        tests++; if (a_dn_pc !== 32'h10) begin fails++; $display("FAIL stall_two_pc got %h want 10", a_dn_pc); end
        a_up_valid = 1'b0;
        step();
        tests++; if (a_dn_pc !== 32'h10 || a_dn_inst !== inst_of(32'h10) || a_dn_valid !== 1'b1) begin
            fails++; $display("FAIL stall_hold got v=%0b pc=%h inst=%h want v=1 pc=10", a_dn_valid, a_dn_pc, a_dn_inst);
        end
        a_dn_ready = 1'b1;
        step();
        tests++; if (a_dn_pc !== 32'h14 || a_dn_inst !== inst_of(32'h14) || a_up_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release got pc=%h inst=%h rdy=%0b want pc=14 rdy=1", a_dn_pc, a_dn_inst, a_up_ready);
        end
        step();
        tests++; if (a_dn_valid !== 1'b0) begin fails++; $display("FAIL stall_empty got %0b want 0", a_dn_valid); end
    endtask

    task automatic test_flush();
        a_dn_ready = 1'b0;
        a_up_valid = 1'b1; a_up_pc = 32'h18; a_up_inst = inst_of(32'h18);
        step();
        a_up_pc = 32'h1C; a_up_inst = inst_of(32'h1C);
        step();
        tests++; if (a_up_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_two got rdy=%0b want 0", a_up_ready); end
        a_flush = 1'b1; a_up_pc = 32'h20; a_up_inst = inst_of(32'h20);
        step();
        tests++; if (a_dn_valid !== 1'b0 || a_dn_pc !== 32'h0 || a_up_ready !== 1'b1) begin
            fails++; $display("FAIL flush_empty got v=%0b pc=%h rdy=%0b want v=0 pc=0 rdy=1", a_dn_valid, a_dn_pc, a_up_ready);
        end
        a_flush = 1'b0; a_up_pc = 32'h24; a_up_inst = inst_of(32'h24); a_dn_ready = 1'b1;
        step();
        tests++; if (a_dn_valid !== 1'b1 || a_dn_pc !== 32'h24) begin fails++; $display("FAIL flush_next got v=%0b pc=%h want v=1 pc=24", a_dn_valid, a_dn_pc); end
        a_up_valid = 1'b0;
        step();
        tests++; if (a_dn_valid !== 1'b0) begin fails++; $display("FAIL flush_drain got %0b want 0", a_dn_valid); end
    endtask

    task automatic test_noskid();
        b_dn_ready = 1'b0;
        b_up_valid = 1'b1; b_up_pc = 32'h30; b_up_inst = inst_of(32'h30);
        #1;
        tests++; if (b_up_ready !== 1'b1) begin fails++; $display("FAIL noskid_empty_ready got %0b want 1", b_up_ready); end
        step();
        tests++; if (b_dn_valid !== 1'b1 || b_dn_pc !== 32'h30 || b_up_ready !== 1'b0) begin
            fails++; $display("FAIL noskid_stall got v=%0b pc=%h rdy=%0b want v=1 pc=30 rdy=0", b_dn_valid, b_dn_pc, b_up_ready);
        end
        b_up_pc = 32'h34; b_up_inst = inst_of(32'h34);
        step();
        tests++; if (b_dn_pc !== 32'h30) begin fails++; $display("FAIL noskid_hold got %h want 30", b_dn_pc); end
        b_dn_ready = 1'b1;
        #1;
        tests++; if (b_up_ready !== 1'b1) begin fails++; $display("FAIL noskid_comb_ready got %0b want 1", b_up_ready); end
        step();
        tests++; if (b_dn_pc !== 32'h34 || b_dn_inst !== inst_of(32'h34)) begin fails++; $display("FAIL noskid_replace got pc=%h inst=%h want pc=34", b_dn_pc, b_dn_inst); end
        b_up_pc = 32'h38; b_up_inst = inst_of(32'h38);
        step();
        tests++; if (b_dn_pc !== 32'h38) begin fails++; $display("FAIL noskid_back_to_back got %h want 38", b_dn_pc); end
        b_up_valid = 1'b0;
        step();
        tests++; if (b_dn_valid !== 1'b0) begin fails++; $display("FAIL noskid_drain got %0b want 0", b_dn_valid); end
    endtask

    task automatic test_reset_mid();
        a_dn_ready = 1'b0; b_dn_ready = 1'b0;
        a_up_valid = 1'b1; a_up_pc = 32'h40; a_up_inst = inst_of(32'h40);
        b_up_valid = 1'b1; b_up_pc = 32'h50; b_up_inst = inst_of(32'h50);
        step();
        b_up_valid = 1'b0;
        a_up_pc = 32'h44; a_up_inst = inst_of(32'h44);
        step();
        a_up_valid = 1'b0;
        tests++; if (a_up_ready !== 1'b0 || b_dn_valid !== 1'b1) begin fails++; $display("FAIL rstmid_setup got a_rdy=%0b b_v=%0b want 0 1", a_up_ready, b_dn_valid); end
        #2 rst = 1'b0;
        #1;
        tests++; if (a_dn_valid !== 1'b0 || a_dn_pc !== 32'h0 || a_dn_inst !== 32'h0) begin
            fails++; $display("FAIL rstmid_a_out got v=%0b pc=%h inst=%h want all 0", a_dn_valid, a_dn_pc, a_dn_inst);
        end
        tests++; if (a_up_ready !== 1'b1) begin fails++; $display("FAIL rstmid_a_ready got %0b want 1", a_up_ready); end
        tests++; if (b_dn_valid !== 1'b0 || b_dn_pc !== 32'h0 || b_up_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_b got v=%0b pc=%h rdy=%0b want 0 0 1", b_dn_valid, b_dn_pc, b_up_ready);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        a_dn_ready = 1'b1; b_dn_ready = 1'b1;
        step();
        tests++; if (a_dn_valid !== 1'b0 || b_dn_valid !== 1'b0) begin fails++; $display("FAIL rstmid_after got a_v=%0b b_v=%0b want 0 0", a_dn_valid, b_dn_valid); end
    endtask

    task automatic test_random();
        logic [31:0] seq_a, seq_b, hold_a, hold_b;
        logic        stall_a, stall_b, a_uf, b_uf;
        seq_a = 32'h1000; seq_b = 32'h8000;
        stall_a = 1'b0; stall_b = 1'b0; hold_a = '0; hold_b = '0;
        for (int c = 0; c < 10000; c++) begin
            tests++; if (a_dn_valid !== (qa_pc.size() != 0)) begin fails++; $display("FAIL rand_a_valid cyc %0d got %0b want %0b", c, a_dn_valid, qa_pc.size() != 0); end
            tests++;
            if (qa_pc.size() != 0) begin
                if (a_dn_pc !== qa_pc[0] || a_dn_inst !== qa_inst[0]) begin fails++; $display("FAIL rand_a_order cyc %0d got %h/%h want %h/%h", c, a_dn_pc, a_dn_inst, qa_pc[0], qa_inst[0]); end
            end else if (a_dn_pc !== 32'h0 || a_dn_inst !== 32'h0) begin
                fails++; $display("FAIL rand_a_bubble cyc %0d got %h/%h want 0/0", c, a_dn_pc, a_dn_inst);
            end
            tests++; if (a_up_ready !== (qa_pc.size() < 2)) begin fails++; $display("FAIL rand_a_ready cyc %0d got %0b want %0b", c, a_up_ready, qa_pc.size() < 2); end
            tests++; if (b_dn_valid !== (qb_pc.size() != 0)) begin fails++; $display("FAIL rand_b_valid cyc %0d got %0b want %0b", c, b_dn_valid, qb_pc.size() != 0); end
            tests++;
            if (qb_pc.size() != 0) begin
                if (b_dn_pc !== qb_pc[0] || b_dn_inst !== qb_inst[0]) begin fails++; $display("FAIL rand_b_order cyc %0d got %h/%h want %h/%h", c, b_dn_pc, b_dn_inst, qb_pc[0], qb_inst[0]); end
            end else if (b_dn_pc !== 32'h0 || b_dn_inst !== 32'h0) begin
                fails++; $display("FAIL rand_b_bubble cyc %0d got %h/%h want 0/0", c, b_dn_pc, b_dn_inst);
            end
            if (stall_a) begin
                tests++; if (a_dn_pc !== hold_a) begin fails++; $display("FAIL rand_a_stable cyc %0d got %h want %h", c, a_dn_pc, hold_a); end
            end
            if (stall_b) begin
                tests++; if (b_dn_pc !== hold_b) begin fails++; $display("FAIL rand_b_stable cyc %0d got %h want %h", c, b_dn_pc, hold_b); end
            end

            a_up_valid = ($urandom_range(0, 99) < 70);
            a_dn_ready = ($urandom_range(0, 99) < 60);
            a_flush    = ($urandom_range(0, 99) < 4);
            a_up_pc    = seq_a;
            a_up_inst  = $urandom;
            b_up_valid = ($urandom_range(0, 99) < 70);
            b_dn_ready = ($urandom_range(0, 99) < 60);
            b_flush    = ($urandom_range(0, 99) < 4);
            b_up_pc    = seq_b;
            b_up_inst  = $urandom;
            #1;
            tests++; if (b_up_ready !== ((qb_pc.size() == 0) || b_dn_ready)) begin fails++; $display("FAIL rand_b_ready cyc %0d got %0b want %0b", c, b_up_ready, (qb_pc.size() == 0) || b_dn_ready); end

            a_uf = a_up_valid & a_up_ready & ~a_flush;
            b_uf = b_up_valid & b_up_ready & ~b_flush;
            stall_a = a_dn_valid & ~a_dn_ready & ~a_flush;
            stall_b = b_dn_valid & ~b_dn_ready & ~b_flush;
            hold_a = a_dn_pc;
            hold_b = b_dn_pc;
            if (a_dn_valid && a_dn_ready && qa_pc.size() != 0) begin void'(qa_pc.pop_front()); void'(qa_inst.pop_front()); end
            if (b_dn_valid && b_dn_ready && qb_pc.size() != 0) begin void'(qb_pc.pop_front()); void'(qb_inst.pop_front()); end
            if (a_flush) begin qa_pc.delete(); qa_inst.delete(); end
            else if (a_uf) begin qa_pc.push_back(a_up_pc); qa_inst.push_back(a_up_inst); seq_a = seq_a + 32'd4; end
            if (b_flush) begin qb_pc.delete(); qb_inst.delete(); end
            else if (b_uf) begin qb_pc.push_back(b_up_pc); qb_inst.push_back(b_up_inst); seq_b = seq_b + 32'd4; end
            step();
        end
        a_up_valid = 1'b0; a_flush = 1'b0;
        b_up_valid = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        a_up_valid = 1'b0; a_flush = 1'b0; a_dn_ready = 1'b0; a_up_pc = '0; a_up_inst = '0;
        b_up_valid = 1'b0; b_flush = 1'b0; b_dn_ready = 1'b0; b_up_pc = '0; b_up_inst = '0;
        #1 rst = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_noskid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
